// File: rtl/key_shift_sequencer_if.sv
// Bus bundle for key_shift_sequencer: key/period request side plus the serial bit stream outputs.
interface key_shift_sequencer_if #(
   parameter int KEY_W = 128,
   parameter int PER_W = 16
);
   logic [KEY_W-1:0] key;
   logic             start;
   logic [PER_W-1:0] period;
   logic             abort;
   logic             bit_out;
   logic             bit_valid;
   logic [7:0]       bit_idx;
   logic             busy;
   logic             done;

   modport master (
      output key, start, period, abort,
      input  bit_out, bit_valid, bit_idx, busy, done
   );

   modport slave (
      input  key, start, period, abort,
      output bit_out, bit_valid, bit_idx, busy, done
   );
endinterface

// File: rtl/key_shift_sequencer.sv
// Serializes a captured key LSB-first, one bit every P clocks, then pulses done.
// Optional feature macro: KEY_SHIFT_PARITY_EN appends an XOR-parity bit at index KEY_W.
module key_shift_sequencer #(
   parameter int KEY_W = 128,
   parameter int PER_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   key_shift_sequencer_if.slave  bus
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam int IDX_W = $clog2(KEY_W + 2);
`ifdef KEY_SHIFT_PARITY_EN
   localparam int LAST_IDX = KEY_W;
`else
   localparam int LAST_IDX = KEY_W - 1;
`endif
   localparam logic [PER_W-1:0] PER_ONE = {{(PER_W-1){1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

   logic [1:0]       r_state;
   logic [KEY_W-1:0] r_shadow;
   logic [PER_W-1:0] r_per;
   logic [PER_W-1:0] r_cnt;
   logic [IDX_W-1:0] r_next_idx;
   logic             r_bit_out;
   logic             r_bit_valid;
   logic [7:0]       r_bit_idx;
   logic             r_busy;
   logic             r_done;

   logic [PER_W-1:0] w_per_eff;
   logic             w_last;
   logic             w_emit_bit;

   // A zero period would never let the interval counter expire, so it runs as one clock per bit.
   assign w_per_eff = (bus.period == {PER_W{1'b0}}) ? PER_ONE : bus.period;
   assign w_last    = (r_next_idx == IDX_W'(LAST_IDX));

`ifdef KEY_SHIFT_PARITY_EN
   logic r_parity;

   function automatic logic f_parity(input logic [KEY_W-1:0] v);
      return ^v;
   endfunction

   // Parity of the key as captured, emitted after the data bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_parity <= 1'b0;
      end else if ((r_state == ST_IDLE) && bus.start && !bus.abort) begin
         r_parity <= f_parity(bus.key);
      end else begin
         r_parity <= r_parity;
      end
   end

   assign w_emit_bit = (r_next_idx == IDX_W'(KEY_W)) ? r_parity : r_shadow[0];
`else
   assign w_emit_bit = r_shadow[0];
`endif

   // Sequencer FSM together with the shadow shifter, interval counter and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_shadow    <= {KEY_W{1'b0}};
         r_per       <= {PER_W{1'b0}};
         r_cnt       <= {PER_W{1'b0}};
         r_next_idx  <= {IDX_W{1'b0}};
         r_bit_out   <= 1'b0;
         r_bit_valid <= 1'b0;
         r_bit_idx   <= 8'd0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_bit_valid <= 1'b0;
         r_done      <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_busy <= 1'b0;
               if (bus.start && !bus.abort) begin
                  r_shadow   <= bus.key;
                  r_per      <= w_per_eff;
                  r_cnt      <= w_per_eff - PER_ONE;
                  r_next_idx <= {IDX_W{1'b0}};
                  r_state    <= ST_SHIFT;
                  r_busy     <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (bus.abort) begin
                  r_state  <= ST_IDLE;
                  r_shadow <= {KEY_W{1'b0}};
                  r_cnt    <= {PER_W{1'b0}};
                  r_busy   <= 1'b0;
               end else if (r_cnt != {PER_W{1'b0}}) begin
                  r_cnt <= r_cnt - PER_ONE;
               end else begin
                  r_bit_out   <= w_emit_bit;
                  r_bit_valid <= 1'b1;
                  r_bit_idx   <= 8'(r_next_idx);
                  r_shadow    <= r_shadow >> 1;
                  r_cnt       <= r_per - PER_ONE;
                  r_next_idx  <= r_next_idx + IDX_ONE;
                  if (w_last) begin
                     r_state <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               // Abort here still cancels the pending done pulse.
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               if (bus.abort) begin
                  r_shadow <= {KEY_W{1'b0}};
                  r_cnt    <= {PER_W{1'b0}};
               end else begin
                  r_done <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.bit_out   = r_bit_out;
   assign bus.bit_valid = r_bit_valid;
   assign bus.bit_idx   = r_bit_idx;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
endmodule
